// File: rtl/map_renderer.sv
// map_renderer: draws an 8x8 minesweeper board as 4x4-pixel cells.
// A start pulse in IDLE takes a snapshot of the four maps and lose.
// The block then streams the 1024 pixels of the frame to a pixel sink
// that uses a valid/ready handshake.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start                 frame request; sampled only in IDLE
//   MMin_map/FM_map/
//   SM_map/PM_map         mine, flag, step and cursor maps; bit i is cell i
//   lose                  game-lost flag
//   plot_ready            sink accepts the current pixel
//   x, y, colour, plot    pixel coordinate, {R,G,B} colour and valid
//   busy                  high while a frame is in progress
//   done                  one-cycle end-of-frame pulse
module map_renderer #(
  parameter int unsigned X_ORIGIN = 0,
  parameter int unsigned Y_ORIGIN = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] MMin_map,
  input  logic [63:0] FM_map,
  input  logic [63:0] SM_map,
  input  logic [63:0] PM_map,
  input  logic        lose,
  input  logic        plot_ready,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCell = 2'd1;
  localparam logic [1:0] StDraw = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [3:0]  p_q, p_d;
  logic [63:0] mm_q, fm_q, sm_q, pm_q;
  logic        lose_q;
  logic [2:0]  cell_col_q, cell_col_d;
  logic        snap;

  logic [2:0] row, col;
  logic [3:0] nb_cnt;

  assign row = idx_q[5:3];
  assign col = idx_q[2:0];

  // Mines among the in-range neighbours. Rows and columns are bounded
  // separately, so there is no wrap from column 7 into column 0.
  always_comb begin
    nb_cnt = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (!(dr == 0 && dc == 0) &&
            (int'(row) + dr >= 0) && (int'(row) + dr <= 7) &&
            (int'(col) + dc >= 0) && (int'(col) + dc <= 7)) begin
          nb_cnt = nb_cnt + 4'(mm_q[6'((int'(row) + dr) * 8 + int'(col) + dc)]);
        end
      end
    end
  end

  // Cell colour, first match wins.
  always_comb begin
    cell_col_d = 3'b000;
    if (pm_q[idx_q]) begin
      cell_col_d = 3'b110;
    end else if (lose_q && mm_q[idx_q]) begin
      cell_col_d = 3'b100;
    end else if (fm_q[idx_q]) begin
      cell_col_d = 3'b101;
    end else if (sm_q[idx_q]) begin
      case (nb_cnt)
        4'd0:    cell_col_d = 3'b111;
        4'd1:    cell_col_d = 3'b001;
        4'd2:    cell_col_d = 3'b010;
        default: cell_col_d = 3'b011;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    p_d     = p_q;
    snap    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          snap    = 1'b1;
          idx_d   = '0;
          state_d = StCell;
        end
      end
      StCell: begin
        p_d     = '0;
        state_d = StDraw;
      end
      StDraw: begin
        if (plot_ready) begin
          if (p_q == 4'd15) begin
            if (idx_q == 6'd63) begin
              state_d = StDone;
            end else begin
              idx_d   = idx_q + 6'd1;
              state_d = StCell;
            end
          end else begin
            p_d = p_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      p_q        <= '0;
      mm_q       <= '0;
      fm_q       <= '0;
      sm_q       <= '0;
      pm_q       <= '0;
      lose_q     <= 1'b0;
      cell_col_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      p_q     <= p_d;
      if (snap) begin
        mm_q   <= MMin_map;
        fm_q   <= FM_map;
        sm_q   <= SM_map;
        pm_q   <= PM_map;
        lose_q <= lose;
      end
      if (state_q == StCell) begin
        cell_col_q <= cell_col_d;
      end
    end
  end

  // Outputs depend only on registers. p does not move while the sink
  // stalls, so the pixel holds until it is accepted.
  always_comb begin
    plot   = (state_q == StDraw);
    busy   = (state_q != StIdle);
    done   = (state_q == StDone);
    x      = '0;
    y      = '0;
    colour = '0;
    if (plot) begin
      x      = 8'(X_ORIGIN) + {3'b000, col, 2'b00} + {6'b0, p_q[1:0]};
      y      = 7'(Y_ORIGIN) + {2'b00, row, 2'b00} + {5'b0, p_q[3:2]};
      colour = cell_col_q;
    end
  end

endmodule

// File: tb/tb_map_renderer.sv
// Scoreboard bench for map_renderer. The expected pixel stream comes from
// an independent model. It is queued at start and popped on each accepted pixel.
module tb_map_renderer;

  logic        clk = 1'b0;
  logic        reset, start, lose, plot_ready;
  logic [63:0] mm, fm, sm, pm;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, busy, done;

  int n_checks = 0;
  int n_errors = 0;
  logic [17:0] exp_q[$];
  logic [2:0]  cell_col[64];

  always #5 clk = ~clk;

  map_renderer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .MMin_map   (mm),
    .FM_map     (fm),
    .SM_map     (sm),
    .PM_map     (pm),
    .lose       (lose),
    .plot_ready (plot_ready),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  function automatic logic [2:0] model_col(input int i);
    int n = 0;
    int dr, dc;
    for (int j = 0; j < 64; j++) begin
      dr = j / 8 - i / 8;
      dc = j % 8 - i % 8;
      if (j != i && dr >= -1 && dr <= 1 && dc >= -1 && dc <= 1 && mm[j]) n++;
    end
    if (pm[i]) return 3'b110;
    if (lose && mm[i]) return 3'b100;
    if (fm[i]) return 3'b101;
    if (sm[i]) begin
      if (n == 0) return 3'b111;
      if (n == 1) return 3'b001;
      if (n == 2) return 3'b010;
      return 3'b011;
    end
    return 3'b000;
  endfunction

  // Runs one frame. Stalls the sink for stall_len cycles at cell 0, p=3,
  // scrambles the maps at change_at, and pulses start at extra_start_at.
  // If reset_at_pix >= 0, resets once that many pixels have been accepted.
  task automatic run_frame(input int stall_len, input int change_at,
                           input int reset_at_pix, input int extra_start_at);
    int cyc = 1;
    int npix = 0;
    int stall_left = stall_len;
    int first_at = -1;
    int last_at = -1;
    int done_at = -1;
    logic [2:0]  c;
    logic [17:0] e;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      c = model_col(i);
      for (int p = 0; p < 16; p++)
        exp_q.push_back({8'((i % 8) * 4 + p % 4), 7'((i / 8) * 4 + p / 4), c});
    end
    @(negedge clk);
    start = 1'b1;
    plot_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 1200 + stall_len) begin
      if (cyc == change_at) begin
        mm = {$urandom, $urandom};
        fm = {$urandom, $urandom};
        sm = {$urandom, $urandom};
        pm = {$urandom, $urandom};
        lose = ~lose;
      end
      start = (cyc == extra_start_at);
      plot_ready = 1'b1;
      if (reset_at_pix >= 0 && npix == reset_at_pix) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_plot", 32'(plot), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_x", 32'(x), 0);
        exp_q.delete();
        return;
      end
      if (npix == 3 && stall_left > 0) begin
        plot_ready = 1'b0;
        stall_left--;
        check("hold_plot", 32'(plot), 1);
        check("hold_x", 32'(x), 3);
        check("hold_y", 32'(y), 0);
      end
      if (plot && first_at < 0) first_at = cyc;
      if (plot && plot_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_pix", 32'(npix), 1024);
        end else begin
          e = exp_q.pop_front();
          check("pix", 32'({x, y, colour}), 32'(e));
        end
        if (npix < 1024) cell_col[npix / 16] = colour;
        last_at = cyc;
        npix++;
      end
      if (done) begin
        if (done_at >= 0) check("done_twice", cyc, done_at);
        else done_at = cyc;
      end
      cyc++;
      @(negedge clk);
      if (done_at >= 0 && cyc > done_at + 2) break;
    end
    check("first_plot", first_at, 2);
    check("last_plot", last_at, 1088 + stall_len);
    check("done_cyc", done_at, 1089 + stall_len);
    check("npix", npix, 1024);
    check("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    lose = 1'b0;
    plot_ready = 1'b1;
    mm = '0; fm = '0; sm = '0; pm = '0;
    repeat (2) @(negedge clk);
    check("rst_state", 32'({x, y, colour, plot, busy, done}), 0);
    reset = 1'b0;

    // Blank board.
    run_frame(0, -1, -1, -1);
    check("blank_c0", 32'(cell_col[0]), 0);

    // Neighbour count with no wrap at the row edge.
    mm = 64'd1 << 7;
    sm = (64'd1 << 6) | (64'd1 << 8);
    run_frame(0, -1, -1, -1);
    check("c6", 32'(cell_col[6]), 3'b001);
    check("c7", 32'(cell_col[7]), 3'b000);
    check("c8", 32'(cell_col[8]), 3'b111);

    // Priority of cursor, lost mine and flag.
    mm = 64'd1 << 9; fm = 64'd1 << 9; pm = 64'd1 << 9; sm = '0; lose = 1'b1;
    run_frame(0, -1, -1, -1);
    check("c9_pm", 32'(cell_col[9]), 3'b110);
    pm = '0;
    run_frame(0, -1, -1, -1);
    check("c9_lose", 32'(cell_col[9]), 3'b100);
    lose = 1'b0;
    run_frame(0, -1, -1, -1);
    check("c9_flag", 32'(cell_col[9]), 3'b101);

    // Sink stall on the fourth pixel.
    run_frame(5, -1, -1, -1);

    // Snapshot isolation and start ignored mid-frame.
    mm = {$urandom, $urandom} & {$urandom, $urandom};
    sm = {$urandom, $urandom};
    fm = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
    pm = 64'd1 << $urandom_range(63);
    lose = 1'b1;
    run_frame(0, 100, -1, 500);

    for (int k = 0; k < 2; k++) begin
      mm = {$urandom, $urandom} & {$urandom, $urandom};
      sm = {$urandom, $urandom} | {$urandom, $urandom};
      fm = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      pm = '0;
      lose = 1'($urandom_range(1));
      run_frame(0, -1, -1, -1);
    end

    // Reset while drawing cell 20, then a full frame from cell 0.
    run_frame(0, -1, 20 * 16 + 5, -1);
    @(negedge clk);
    check("rst_idle", 32'(busy), 0);
    run_frame(0, -1, -1, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
